// File: rtl/dbus_responder.sv
// ---------------------------------------------------------------------------
// dbus_responder -- single-outstanding data-bus target backed by a word store
//
// Accepts one request at a time, holds it for a fixed number of cycles and
// then completes it with a one-cycle addr_ok/data_ok pulse. A request with an
// all-zero strobe is a read; any other strobe is a byte-masked write that
// returns the pre-write word. Addresses outside the store complete with zero
// data and never write. Dropping valid while the request is still counting
// down abandons it.
//
// Parameters
//   MEM_WORDS  number of 64-bit words in the backing store
//   LATENCY    cycles from acceptance to data_ok (1..15)
//   BASE_ADDR  byte address of word 0
//
// Ports
//   clk    in   sole clock, rising edge
//   reset  in   synchronous, active-high reset
//   dreq   in   initiator request  (valid, addr, size, strobe, data)
//   dresp  out  responder reply    (addr_ok, data_ok, data), all registered
// ---------------------------------------------------------------------------

package dbus_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

module dbus_responder
    import dbus_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int         IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t           r_state;
    logic [3:0]       r_count;
    logic [IDX_W-1:0] r_idx;
    logic             r_hit;
    logic [7:0]       r_strobe;
    logic [63:0]      r_wdata;
    logic             r_ok;
    logic [63:0]      r_rdata;

    logic [63:0]      r_mem [MEM_WORDS];

    // ------------------------------------------------------------------
    // Address decode of the incoming request. Only the result is latched
    // at acceptance, so later changes on dreq.addr cannot disturb a
    // transaction in flight.
    // ------------------------------------------------------------------
    logic [63:0]      w_off;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;

    assign w_off      = dreq.addr - BASE_ADDR;
    assign w_in_range = (dreq.addr >= BASE_ADDR) &&
                        ({3'b000, w_off[63:3]} < 64'(MEM_WORDS));
    assign w_idx      = w_off[IDX_W+2:3];

    // The store is read on the edge that opens the data_ok cycle. With
    // LATENCY=1 that is the acceptance edge itself, so the freshly decoded
    // address is used; otherwise the latched copy is.
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_rd_hit;

    assign w_rd_idx = (r_state == IDLE) ? w_idx      : r_idx;
    assign w_rd_hit = (r_state == IDLE) ? w_in_range : r_hit;

    // w_fire: the coming edge moves the FSM into its counter==0 BUSY cycle,
    // i.e. the next cycle is the completion cycle.
    logic w_fire;

    assign w_fire = dreq.valid &&
                    (((r_state == IDLE) && (CNT_LOAD == 4'd0)) ||
                     ((r_state == BUSY) && (r_count == 4'd1)));

    // w_commit: the edge that closes the completion cycle of a write that
    // targets a real word. The completion cycle already shows data_ok, so
    // it is finished regardless of valid in that cycle.
    logic w_commit;

    assign w_commit = !reset && (r_state == BUSY) && (r_count == 4'd0) &&
                      r_hit && (r_strobe != 8'h00);

    // Sizes are irrelevant (strobe alone selects bytes) and byte offsets
    // inside a word do not affect indexing.
    logic w_unused;

    assign w_unused = ^{dreq.size, w_off[2:0]};

    // ------------------------------------------------------------------
    // Backing store
    // ------------------------------------------------------------------
    // NOTE: the store has no reset branch on purpose -- contents must
    // survive reset, and a reset would also stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 8; i++) begin
                if (r_strobe[i]) begin
                    r_mem[r_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered reply
    // ------------------------------------------------------------------
    // NOTE: every register here uses <= so all of them update from the
    // same pre-edge values; a blocking = would let later lines see the
    // new state within the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_count  <= 4'd0;
            r_idx    <= '0;
            r_hit    <= 1'b0;
            r_strobe <= 8'h00;
            r_wdata  <= 64'h0;
            r_ok     <= 1'b0;
            r_rdata  <= 64'h0;
        end else begin
            // Reply is non-zero only in the completion cycle; out-of-range
            // requests complete with zero data.
            r_ok    <= w_fire;
            r_rdata <= (w_fire && w_rd_hit) ? r_mem[w_rd_idx] : 64'h0;

            case (r_state)
                IDLE: begin
                    if (dreq.valid) begin
                        r_idx    <= w_idx;
                        r_hit    <= w_in_range;
                        r_strobe <= dreq.strobe;
                        r_wdata  <= dreq.data;
                        r_count  <= CNT_LOAD;
                        r_state  <= BUSY;
                    end
                end

                BUSY: begin
                    if (r_count == 4'd0) begin
                        // Completion cycle: back to IDLE, so a request
                        // still held valid is taken in the next cycle,
                        // never in this one.
                        r_state <= IDLE;
                    end else if (!dreq.valid) begin
                        // Initiator gave up before completion.
                        r_state <= IDLE;
                        r_count <= 4'd0;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_count <= 4'd0;
                end
            endcase
        end
    end

    assign dresp.addr_ok = r_ok;
    assign dresp.data_ok = r_ok;
    assign dresp.data    = r_rdata;

endmodule

// File: tb/tb_dbus_responder.sv
// ---------------------------------------------------------------------------
// tb_dbus_responder -- directed, scoreboarded bench for dbus_responder
//
// Four responders with LATENCY 1..4 share clock and reset; instance k has
// LATENCY k+1. Expected read data is computed by a small memory model and
// pushed when a request is driven, then popped when the DUT raises data_ok.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------

module tb_dbus_responder;
    import dbus_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          WORDS = 4096;

    typedef struct {
        logic [63:0] d;
        bit          care;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  req  [4];
    dbus_resp_t resp [4];

    int          vectors     = 0;
    int          miscompares = 0;
    exp_t        sb [$];
    logic [63:0] mdl [int];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        dbus_responder #(
            .MEM_WORDS (WORDS),
            .LATENCY   (g + 1),
            .BASE_ADDR (BASE)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .dreq  (req[g]),
            .dresp (resp[g])
        );
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference memory: returns the word the DUT must report and applies
    // the write. Words never written fully are unknown and not compared.
    function automatic exp_t model_rw(int k, logic [63:0] a, logic [7:0] s,
                                      logic [63:0] d);
        exp_t        e;
        int          key;
        logic [63:0] w;
        e.care = 1'b1;
        e.d    = 64'h0;
        if (a < BASE || ((a - BASE) >> 3) >= 64'(WORDS)) return e;
        key = k * 8192 + int'((a - BASE) >> 3);
        if (mdl.exists(key)) begin
            w   = mdl[key];
            e.d = w;
        end else begin
            w      = 64'h0;
            e.care = 1'b0;
        end
        if (s != 8'h00 && (e.care || s == 8'hFF)) begin
            for (int i = 0; i < 8; i++) begin
                if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
            end
            mdl[key] = w;
        end
        return e;
    endfunction

    task automatic drive(int k, logic [63:0] a, logic [7:0] s, logic [63:0] d);
        req[k].valid  = 1'b1;
        req[k].addr   = a;
        req[k].size   = 3'd3;
        req[k].strobe = s;
        req[k].data   = d;
        sb.push_back(model_rw(k, a, s, d));
    endtask

    task automatic scramble(int k);
        req[k].addr   = {$urandom, $urandom};
        req[k].data   = {$urandom, $urandom};
        req[k].strobe = 8'($urandom);
        req[k].size   = 3'($urandom);
    endtask

    task automatic expect_cycle(int k, bit exp_ok, string tag);
        exp_t e;
        check({tag, " addr_ok"}, 64'(resp[k].addr_ok), 64'(exp_ok));
        check({tag, " data_ok"}, 64'(resp[k].data_ok), 64'(exp_ok));
        if (resp[k].data_ok) begin
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.care) check({tag, " data"}, resp[k].data, e.d);
            end
        end else begin
            check({tag, " idle data"}, resp[k].data, 64'h0);
        end
    endtask

    // One full transaction on instance k (LATENCY k+1): data_ok expected in
    // cycle k+1 only, request fields scrambled while busy, valid dropped in
    // the first IDLE cycle after completion.
    task automatic txn(int k, logic [63:0] a, logic [7:0] s, logic [63:0] d,
                       string tag);
        drive(k, a, s, d);
        for (int c = 1; c <= k + 2; c++) begin
            tick();
            expect_cycle(k, c == k + 1, $sformatf("%s c%0d", tag, c));
            scramble(k);
            if (c == k + 2) req[k].valid = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 4; k++) req[k] = '0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) expect_cycle(k, 1'b0, $sformatf("in reset u%0d", k));
        reset = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) expect_cycle(k, 1'b0, $sformatf("after reset u%0d", k));

        // LATENCY=2: preload/read, masked write, offset bits ignored
        txn(1, BASE + 64'h10, 8'hFF, 64'hDEAD_BEEF_0123_4567, "preload 0x10");
        txn(1, BASE + 64'h10, 8'h00, 64'h0, "read 0x10");
        txn(1, BASE + 64'h08, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, "preload 0x08");
        txn(1, BASE + 64'h08, 8'h0F, 64'h1111_2222_3333_4444, "masked write 0x08");
        txn(1, BASE + 64'h0D, 8'h00, 64'h0, "read 0x0D");
        txn(1, BASE + 64'h08, 8'h00, 64'h0, "read 0x08");

        // LATENCY=2: out-of-range below and above the store
        txn(1, BASE, 8'hFF, 64'h0123_4567_89AB_CDEF, "preload word0");
        txn(1, BASE + 64'(8 * (WORDS - 1)), 8'hFF, 64'hFEDC_BA98_7654_3210, "preload last");
        txn(1, 64'h7FFF_FFF8, 8'h00, 64'h0, "read below base");
        txn(1, BASE + 64'(8 * WORDS), 8'hFF, 64'h5555_6666_7777_8888, "write past end");
        txn(1, BASE, 8'h00, 64'h0, "word0 after oob");
        txn(1, BASE + 64'(8 * (WORDS - 1)), 8'h00, 64'h0, "last after oob");

        // LATENCY=3: valid dropped one cycle after acceptance
        txn(2, BASE + 64'h20, 8'hFF, 64'h0F0F_1E1E_2D2D_3C3C, "preload abort word");
        req[2].valid  = 1'b1;
        req[2].addr   = BASE + 64'h20;
        req[2].strobe = 8'hFF;
        req[2].data   = 64'hBADB_ADBA_DBAD_BADB;
        tick();
        expect_cycle(2, 1'b0, "abort c1");
        req[2].valid = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            tick();
            expect_cycle(2, 1'b0, $sformatf("abort c%0d", c));
        end
        txn(2, BASE + 64'h20, 8'h00, 64'h0, "read after abort");

        // LATENCY=1: four reads with valid held continuously
        for (int i = 0; i < 4; i++) begin
            txn(0, BASE + 64'h100 + 64'(8 * i), 8'hFF, {$urandom, $urandom},
                $sformatf("b2b preload %0d", i));
        end
        drive(0, BASE + 64'h100, 8'h00, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_cycle(0, 1'b1, $sformatf("b2b done %0d", i));
            if (i < 3) drive(0, BASE + 64'h100 + 64'(8 * (i + 1)), 8'h00, 64'h0);
            tick();
            expect_cycle(0, 1'b0, $sformatf("b2b gap %0d", i));
        end
        req[0].valid = 1'b0;
        tick();
        expect_cycle(0, 1'b0, "b2b no duplicate");

        // LATENCY=4: reset one cycle after a write is accepted
        txn(3, BASE + 64'h40, 8'hFF, 64'h7777_0000_7777_0000, "preload rst word");
        txn(3, BASE + 64'h48, 8'hFF, 64'h4848_4848_4848_4848, "preload rst nbr");
        req[3].valid  = 1'b1;
        req[3].addr   = BASE + 64'h40;
        req[3].strobe = 8'hFF;
        req[3].data   = 64'h9999_9999_9999_9999;
        tick();
        expect_cycle(3, 1'b0, "rst c1");
        reset = 1'b1;
        tick();
        expect_cycle(3, 1'b0, "rst edge");
        reset        = 1'b0;
        req[3].valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            expect_cycle(3, 1'b0, $sformatf("after rst %0d", c));
        end
        txn(3, BASE + 64'h40, 8'h00, 64'h0, "rst word intact");
        txn(3, BASE + 64'h48, 8'h00, 64'h0, "rst nbr intact");
        txn(1, BASE + 64'h10, 8'h00, 64'h0, "u1 intact after rst");

        check("scoreboard drained", 64'(sb.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 Parameter MEM_WORDS, 4096, number of 64-bit words in the backing store.
REQ-002 Parameter LATENCY, 2, cycles from request acceptance to data_ok; legal range 1..15.
REQ-003 Parameter BASE_ADDR, 64'h8000_0000, byte address of word 0.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port dreq  input  dbus_req_t  initiator request: valid(1), addr(64), size(3), strobe(8), data(64).
REQ-007 Port dresp  output  dbus_resp_t  responder reply: addr_ok(1), data_ok(1), data(64).

Function
REQ-008 The block SHALL implement a two-state FSM: IDLE and BUSY.
REQ-009 In IDLE with dreq.valid=1 at edge T, the block SHALL latch addr, strobe and data, load a down-counter with LATENCY-1, and enter BUSY at T+1.
REQ-010 In IDLE, dresp.addr_ok, dresp.data_ok SHALL be 0 and dresp.data SHALL be 0.
REQ-011 In BUSY with counter != 0 and dreq.valid=1, the counter SHALL decrement by 1 per cycle; outputs SHALL stay 0.
REQ-012 In BUSY with counter == 0, dresp.addr_ok and dresp.data_ok SHALL both be 1 for exactly that cycle, the FSM SHALL return to IDLE at the next edge; the first data_ok therefore appears in cycle T+LATENCY.
REQ-013 Word index SHALL be (latched addr - BASE_ADDR) >> 3; addr[2:0] SHALL be ignored for indexing; size SHALL be ignored (strobe alone governs writes).
REQ-014 Read (latched strobe == 0): dresp.data in the data_ok cycle SHALL equal the full 64-bit stored word at the index.
REQ-015 Write (latched strobe != 0): at the data_ok edge, byte i of the stored word SHALL take byte i of latched data for every strobe[i]=1; other bytes unchanged; dresp.data in that cycle SHALL be the pre-write word.
REQ-016 Out-of-range address (below BASE_ADDR or index >= MEM_WORDS): transaction SHALL complete with normal timing, dresp.data = 0, no write performed.
REQ-017 If dreq.valid=0 in any BUSY cycle, the transaction SHALL abort: FSM to IDLE at next edge, no data_ok, no write.
REQ-018 Changes to dreq.addr/strobe/data while BUSY SHALL have no effect (latched copies used).
REQ-019 A new request SHALL be accepted in the first IDLE cycle after data_ok (back-to-back throughput one transaction per LATENCY+1 cycles); a request held valid through data_ok SHALL NOT be accepted twice in the data_ok cycle itself.
REQ-020 Write-then-read to the same word SHALL return the written value (no stale data).

Reset
REQ-021 While reset=1 at an edge: FSM to IDLE, counter to 0, all dresp fields 0 from the next cycle.
REQ-022 Reset mid-transaction SHALL abort it with no write and no data_ok.
REQ-023 Backing-store contents SHALL NOT be cleared by reset.

Verification
REQ-024 LATENCY=2: read word at 0x8000_0010 preloaded 64'hDEAD_BEEF_0123_4567, valid at T -> data_ok=addr_ok=1 only at T+2, data=64'hDEAD_BEEF_0123_4567, IDLE at T+3.
REQ-025 Write 0x8000_0008, strobe 8'h0F, data 64'h1111_2222_3333_4444 over 64'hAAAA_BBBB_CCCC_DDDD, then read -> read returns 64'hAAAA_BBBB_3333_4444.
REQ-026 Drop valid at T+1 of a write (LATENCY=3) -> no data_ok ever, word unchanged, next request accepted normally.
REQ-027 Read 0x7FFF_FFF8 and write 0x8000_0000+8*MEM_WORDS -> both complete at T+LATENCY with data 0; memory unchanged.
REQ-028 valid held continuously, LATENCY=1, four reads to consecutive words -> data_ok pulses every 2 cycles, each with correct word, no duplicate completions.
REQ-029 Assert reset at T+1 of a LATENCY=4 write -> outputs 0 from next cycle, no write, previously stored words intact after reset.
